// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX message arbiter.
// Optional CR/LF trailer is enabled by defining UART_TX_ARB_CRLF_EN.
package uart_arb_pkg;

    localparam int NUM_REQ_DEFAULT = 4;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        CR     = 2'd2,
        LF     = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping modulo NUM_REQ, returned one-hot together with a hit flag.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               hit
);

    always_comb begin
        pick = '0;
        hit  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!hit && (i == (int'(ptr) + k) % NUM_REQ) && req[i]) begin
                    pick[i] = 1'b1;
                    hit     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin arbiter in front of the UART TX FIFO push port.
// Define UART_TX_ARB_CRLF_EN to append 0x0D 0x0A after every completed message.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEFAULT,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 fifo_full,
    output logic                 fifo_push,
    output logic [7:0]           fifo_wdata,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 timeout_err,
    output arb_state_t           state_dbg
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    // Abort decided on the idle cycle whose increment would reach TIMEOUT_CYC-1.
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC - 2);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tmo_q, tmo_d;

    logic [NUM_REQ-1:0] pick;
    logic               hit;
    logic [PTR_W-1:0]   pick_idx;
    logic               own_valid;
    logic               own_last;
    logic [7:0]         own_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req  (req_valid),
        .ptr  (ptr_q),
        .pick (pick),
        .hit  (hit)
    );

    // ptr_q doubles as the owner index while a message is in flight.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        pick_idx  = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ptr_q == PTR_W'(i)) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[i*8 +: 8];
            end
            if (pick[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        tmo_d      = 1'b0;
        req_ready  = '0;
        fifo_push  = 1'b0;
        fifo_wdata = '0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = STREAM;
                    grant_d = pick;
                    ptr_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            STREAM: begin
                // A full FIFO freezes both the handshake and the idle counter.
                if (!fifo_full) begin
                    req_ready = grant_q;
                    if (own_valid) begin
                        fifo_push  = 1'b1;
                        fifo_wdata = own_data;
                        cnt_d      = '0;
                        if (own_last) begin
`ifdef UART_TX_ARB_CRLF_EN
                            state_d = CR;
`else
                            state_d = IDLE;
                            grant_d = '0;
`endif
                        end
                    end else if (cnt_q == CNT_LIMIT) begin
                        state_d = IDLE;
                        grant_d = '0;
                        cnt_d   = '0;
                        tmo_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_ARB_CRLF_EN
            CR: begin
                if (!fifo_full) begin
                    fifo_push  = 1'b1;
                    fifo_wdata = ASCII_CR;
                    state_d    = LF;
                end
            end
            LF: begin
                if (!fifo_full) begin
                    fifo_push  = 1'b1;
                    fifo_wdata = ASCII_LF;
                    state_d    = IDLE;
                    grant_d    = '0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign grant       = grant_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = tmo_q;
    assign state_dbg   = state_q;

endmodule
